mina_uart_tx: RTL and testbench
===============================

// Module: mina_uart_tx
// PURPOSE
//   Memory-mapped UART transmitter on the MINA CPU DMEM port, downstream of the MEM stage.
//   CPU stores push bytes into a TX FIFO. A baud-rate FSM serialises each byte as 8N1, LSB first, on txd.
//   Register reads are combinational, so the MEM stage receives rddata in the same cycle, as it does from DMEM.
// PARAMETERS
//   FIFO_DEPTH   8        TX FIFO entries; power of two, >= 2
//   DEFAULT_DIV  16'd433  BAUDDIV reset value; bit time = DIV+1 clk cycles (50 MHz -> 115200 baud)
// PORTS
//   clk     in   1   system clock; all state changes on the rising edge
//   rst_n   in   1   asynchronous, active-low reset
//   sel     in   1   address decoder hit for this block's 16-byte window
//   addr    in   32  u32_t byte address; only addr[3:2] is decoded
//   wrdata  in   32  u32_t store data
//   wrstb   in   4   wrstb_t byte write strobes; all-zero = read/no-op
//   rddata  out  32  u32_t combinational read data; 0 when !sel
//   txd     out  1   registered serial output; idle high
//   irq     out  1   level: CTRL.irq_en && FIFO empty && !busy
// BEHAVIOUR
//   Register map (addr[3:2]); a write occurs when sel && wrstb!=0. Reads have no side effects.
//     0x0 TXDATA  W: if wrstb[0], push wrdata[7:0]. Reads return 0.
//     0x4 STATUS  R: [0] busy, [1] full, [2] empty, [3] ovf (sticky), [15:8] count (zero-extended).
//                 W: if wrstb[0] && wrdata[3], clear ovf (W1C).
//     0x8 BAUDDIV RW [15:0]: byte lanes wrstb[1:0]. Latched into active divisor only on START entry.
//     0xC CTRL    RW: [0] enable, [1] irq_en, via wrstb[0].
//   Reset values: txd=1, irq=0, FIFO empty, ovf=0, BAUDDIV=DEFAULT_DIV, CTRL=0x1, FSM=IDLE.
//   Reset STATUS read = 0x0000_0004.
//   FIFO rules:
//     - Push when full and no same-edge pop: byte dropped, ovf set.
//     - Push and pop on the same edge: always accepted; count unchanged, even when full.
//     - ovf set and W1C clear on the same edge: set wins.
//   FSM states IDLE, START, DATA, STOP (uart_state_e).
//     - baud_cnt counts 0..div_active. Each state/bit lasts div_active+1 cycles.
//     - IDLE -> START when enable && !empty: pop into shift reg, latch div_active, txd<=0.
//     - START -> DATA (bit_idx=0). DATA shifts LSB first, txd<=sr[0].
//     - After bit 7, DATA -> STOP (txd<=1).
//     - STOP end: -> START directly when enable && !empty, so frames are back-to-back with no idle gap; else -> IDLE.
//     - Clearing enable mid-frame finishes the frame, then idles. Pushes are still accepted.
//   Latency: a TXDATA write into an empty, idle FIFO commits at edge E0.
//     The pop and START entry occur at E1, so txd is low from E1.
//     Frame = 10*(div+1) cycles.
//   busy = FSM != IDLE.
//   Async reset mid-frame: txd returns high immediately; FIFO and all registers reset.
//   Writes with wrstb lanes not covering a field leave that field unchanged.
//   Unused bits read as 0.
// STRUCTURE
//   types package additions:
//     - uart_state_e
//     - UART_REG_TXDATA/STATUS/BAUDDIV/CTRL offset localparams
//     - uart_status_t packed struct
//   Sub-module fifo_sync #(WIDTH, DEPTH): push/pop/full/empty/count, async active-low reset.
//     Reusable for future RX.
//   Top holds the register file, the address decode and the TX FSM with baud/bit counters.
// TESTING
//   1. Reset -> txd=1, irq=0; STATUS=0x4, BAUDDIV=433, CTRL=0x1.
//   2. DIV=3, write 0x55 -> txd=0 from E1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each).
//      Then stop=1; busy for 40 cycles; returns to IDLE.
//   3. CTRL=0, write 9 bytes (DEPTH=8) -> full=1, count=8, ovf=1, 9th dropped.
//      Set enable -> 8 frames, stop bit immediately followed by start bit.
//   4. STATUS write 0x8 -> ovf=0. W1C on the same edge as an overflowing push -> ovf stays 1.
//   5. FIFO full, push on the same edge the FSM pops -> count stays 8, ovf=0, byte transmitted in order.
//   6. rst_n low mid data bit -> txd=1 asynchronously; after release STATUS=0x4, BAUDDIV=433, no residual frame.

Source files
------------

// File: rtl/mina_uart_tx_pkg.sv
// rtl/mina_uart_tx_pkg.sv - shared types and register offsets for the MINA UART transmitter
package mina_uart_tx_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;

  // Transmit FSM states; busy is any state other than ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] UART_REG_TXDATA  = 4'h0;
  localparam logic [3:0] UART_REG_STATUS  = 4'h4;
  localparam logic [3:0] UART_REG_BAUDDIV = 4'h8;
  localparam logic [3:0] UART_REG_CTRL    = 4'hC;

  // STATUS register image, MSB first
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [3:0]  rsvd_lo;
    logic        ovf;
    logic        empty;
    logic        full;
    logic        busy;
  } uart_status_t;

endpackage

// File: rtl/mina_uart_tx_fifo.sv
// rtl/mina_uart_tx_fifo.sv - synchronous FIFO with first-word fall-through read
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot on the same edge
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage array needs no reset; pointers define which entries are valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mina_uart_tx.sv
// rtl/mina_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module mina_uart_tx
  import mina_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   sel,
  input  u32_t   addr,
  input  u32_t   wrdata,
  input  wrstb_t wrstb,
  output u32_t   rddata,
  output logic   txd,
  output logic   irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e state;
  logic [15:0] baud_cnt;
  logic [15:0] div_active;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;

  logic [15:0] bauddiv;
  logic        enable;
  logic        irq_en;
  logic        ovf;

  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [3:0] reg_off;
  logic       wr_en;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_baud;
  logic       wr_ctrl;
  logic       baud_end;
  logic       fifo_pop;
  logic       push_ok;
  logic       ovf_set;
  logic       ovf_clr;
  logic       busy;

  uart_status_t status;

  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wrdata[31:16]};

  assign reg_off   = {addr[3:2], 2'b00};
  assign wr_en     = sel && (wrstb != '0);
  assign wr_txdata = wr_en && (reg_off == UART_REG_TXDATA) && wrstb[0];
  assign wr_status = wr_en && (reg_off == UART_REG_STATUS);
  assign wr_baud   = wr_en && (reg_off == UART_REG_BAUDDIV);
  assign wr_ctrl   = wr_en && (reg_off == UART_REG_CTRL);

  assign busy     = (state != ST_IDLE);
  assign baud_end = (baud_cnt == div_active);

  // A frame starts from IDLE, or straight out of the last STOP cycle so frames abut
  assign fifo_pop = ((state == ST_IDLE) || ((state == ST_STOP) && baud_end))
                    && enable && !fifo_empty;
  assign push_ok  = wr_txdata && (!fifo_full || fifo_pop);
  assign ovf_set  = wr_txdata && fifo_full && !fifo_pop;
  assign ovf_clr  = wr_status && wrstb[0] && wrdata[3];

  assign irq = irq_en && fifo_empty && !busy;

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (fifo_pop),
    .wdata (wrdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Software-visible registers; a same-edge overflow beats the W1C clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bauddiv <= DEFAULT_DIV;
      enable  <= 1'b1;
      irq_en  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (wr_baud && wrstb[0]) begin
        bauddiv[7:0] <= wrdata[7:0];
      end
      if (wr_baud && wrstb[1]) begin
        bauddiv[15:8] <= wrdata[15:8];
      end
      if (wr_ctrl && wrstb[0]) begin
        enable <= wrdata[0];
        irq_en <= wrdata[1];
      end
    end
  end

  // Transmit FSM: each of start, 8 data and stop bits lasts div_active+1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      div_active <= DEFAULT_DIV;
      bit_idx    <= '0;
      shift_reg  <= '0;
      txd        <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            state      <= ST_START;
            shift_reg  <= fifo_rdata;
            div_active <= bauddiv;
            baud_cnt   <= '0;
            txd        <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            state    <= ST_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              txd       <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (fifo_pop) begin
              state      <= ST_START;
              shift_reg  <= fifo_rdata;
              div_active <= bauddiv;
              txd        <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // Combinational read mux so the MEM stage sees data in the access cycle
  always_comb begin
    status         = '0;
    status.busy    = busy;
    status.full    = fifo_full;
    status.empty   = fifo_empty;
    status.ovf     = ovf;
    status.count   = 8'(fifo_count);
    rddata         = '0;
    if (sel) begin
      case (reg_off)
        UART_REG_STATUS:  rddata = status;
        UART_REG_BAUDDIV: rddata = {16'h0000, bauddiv};
        UART_REG_CTRL:    rddata = {30'h0, irq_en, enable};
        default:          rddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mina_uart_tx.sv
// tb/tb_mina_uart_tx.sv - self-checking bench for mina_uart_tx
module tb_mina_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [31:0] addr;
  logic [31:0] wrdata;
  logic [3:0]  wrstb;
  logic [31:0] rddata;
  logic        txd;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  bit txd_log[$];
  int ev_avail[$];
  int ev_byte[$];
  int ev_pop[$];

  int          e, ee, e9, lo, div, nb, gap;
  logic [31:0] rd;
  logic [7:0]  b;

  typedef struct {
    bit          do_wr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    bit          rsel;
    logic [3:0]  raddr;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[14];

  mina_uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd433)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (sel),
    .addr   (addr),
    .wrdata (wrdata),
    .wrstb  (wrstb),
    .rddata (rddata),
    .txd    (txd),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) txd_log.push_back(txd);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output int edge_id);
    @(negedge clk);
    #1;
    sel = 1'b1; addr = {28'h0, a}; wrdata = d; wrstb = s;
    @(posedge clk);
    #1;
    edge_id = txd_log.size();
    sel = 1'b0; addr = '0; wrdata = '0; wrstb = '0;
  endtask

  task automatic peek(input logic [3:0] a, input logic s, output logic [31:0] d);
    sel = s; addr = {28'h0, a}; wrstb = '0;
    #1;
    d = rddata;
    sel = 1'b0; addr = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic s, output logic [31:0] d);
    @(negedge clk);
    #1;
    peek(a, s, d);
  endtask

  task automatic wait_log(input int n);
    int budget;
    budget = 20000;
    while (txd_log.size() < n && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (txd_log.size() < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_log: log has %0d samples, needed %0d", txd_log.size(), n);
    end
  endtask

  // Frame i begins on the edge after its byte is both written and enabled,
  // but never before the previous frame's ten bit periods have elapsed.
  task automatic compute_pops(input int dv);
    int prev, p;
    prev = -1000000;
    ev_pop.delete();
    for (int i = 0; i < ev_avail.size(); i++) begin
      p = ev_avail[i] + 1;
      if (prev + 10 * (dv + 1) > p) p = prev + 10 * (dv + 1);
      ev_pop.push_back(p);
      prev = p;
    end
  endtask

  function automatic bit exp_bit(input int idx, input int dv, output bit in_frame);
    int fb, k, bb;
    in_frame = 1'b0;
    fb = dv + 1;
    for (int i = 0; i < ev_pop.size(); i++) begin
      if (idx >= ev_pop[i] && idx < ev_pop[i] + 10 * fb) begin
        in_frame = 1'b1;
        k = (idx - ev_pop[i]) / fb;
        bb = ev_byte[i];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return bb[k-1];
      end
    end
    return 1'b1;
  endfunction

  task automatic check_frames(input string name, input int dv, input int lo_idx, input int tail);
    int  flen, hi, bad, bb;
    bit  ev, inf, expv;
    flen = 10 * (dv + 1);
    hi = ev_pop[ev_pop.size()-1] + flen + tail;
    wait_log(hi);
    for (int i = 0; i < ev_pop.size(); i++) begin
      bad = -1;
      expv = 1'b0;
      for (int j = 0; j < flen; j++) begin
        ev = exp_bit(ev_pop[i] + j, dv, inf);
        if (bad < 0 && txd_log[ev_pop[i] + j] != ev) begin
          bad = ev_pop[i] + j;
          expv = ev;
        end
      end
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        bb = ev_byte[i];
        $display("FAIL %s frame %0d (byte 0x%02h): txd=%0d at sample %0d, expected %0d",
                 name, i, bb, txd_log[bad], bad - ev_pop[i], expv);
      end
    end
    bad = -1;
    for (int idx = lo_idx; idx < hi; idx++) begin
      ev = exp_bit(idx, dv, inf);
      if (bad < 0 && !inf && txd_log[idx] != 1'b1) bad = idx;
    end
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s idle: txd=0 at sample %0d outside any frame, expected 1", name, bad);
    end
  endtask

  initial begin
    sel = 1'b0; addr = '0; wrdata = '0; wrstb = '0;
    rst_n = 1'b0;

    // Register vectors: optional write, then one read and the irq level
    vecs[0]  = '{1'b0, 4'h0, 32'h0,         4'h0, 1'b1, 4'h4, 32'h0000_0004, 1'b0};
    vecs[1]  = '{1'b0, 4'h0, 32'h0,         4'h0, 1'b1, 4'h8, 32'h0000_01B1, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,         4'h0, 1'b1, 4'hC, 32'h0000_0001, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 32'h0,         4'h0, 1'b1, 4'h0, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 4'h8, 32'hFFFF_1234, 4'h3, 1'b1, 4'h8, 32'h0000_1234, 1'b0};
    vecs[5]  = '{1'b1, 4'h8, 32'h0000_AB99, 4'h2, 1'b1, 4'h8, 32'h0000_AB34, 1'b0};
    vecs[6]  = '{1'b1, 4'h8, 32'h0000_0056, 4'h1, 1'b1, 4'h8, 32'h0000_AB56, 1'b0};
    vecs[7]  = '{1'b1, 4'h8, 32'h0000_FFFF, 4'hC, 1'b1, 4'h8, 32'h0000_AB56, 1'b0};
    vecs[8]  = '{1'b1, 4'hC, 32'hFFFF_FFFE, 4'h1, 1'b1, 4'hC, 32'h0000_0002, 1'b1};
    vecs[9]  = '{1'b1, 4'hC, 32'h0000_0003, 4'h2, 1'b1, 4'hC, 32'h0000_0002, 1'b1};
    vecs[10] = '{1'b1, 4'h0, 32'h0000_0077, 4'h2, 1'b1, 4'h4, 32'h0000_0004, 1'b1};
    vecs[11] = '{1'b0, 4'h0, 32'h0,         4'h0, 1'b0, 4'hC, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, 4'hC, 32'h0000_0001, 4'h1, 1'b1, 4'hC, 32'h0000_0001, 1'b0};
    vecs[13] = '{1'b1, 4'h8, 32'h0000_0003, 4'h3, 1'b1, 4'h8, 32'h0000_0003, 1'b0};

    #12;
    check("reset_txd", {31'b0, txd}, 32'h1);
    check("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstb, e);
      bus_read(vecs[i].raddr, vecs[i].rsel, rd);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
      check($sformatf("vec%0d_txd", i), {31'b0, txd}, 32'h1);
    end

    // Single 0x55 frame at DIV=3, busy exactly 40 cycles
    bus_write(4'h0, 32'h55, 4'h1, e);
    ev_avail = '{e};
    ev_byte  = '{32'h55};
    compute_pops(3);
    wait_log(e + 41);
    peek(4'h4, 1'b1, rd);
    check("frame55_busy_last", rd & 32'h1, 32'h1);
    wait_log(e + 42);
    peek(4'h4, 1'b1, rd);
    check("frame55_idle_after", rd, 32'h0000_0004);
    check_frames("frame55", 3, e, 8);

    // Overflow with transmitter disabled, W1C behaviour, then 8 abutting frames
    bus_write(4'hC, 32'h0, 4'h1, e);
    ev_avail.delete();
    ev_byte.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      bus_write(4'h0, {24'h0, b}, 4'h1, e);
      if (i < 8) ev_byte.push_back(int'(b));
    end
    bus_read(4'h4, 1'b1, rd);
    check("ovf_status", rd, 32'h0000_080A);
    bus_write(4'h4, 32'h8, 4'h2, e);
    bus_read(4'h4, 1'b1, rd);
    check("ovf_w1c_wrong_lane", rd, 32'h0000_080A);
    bus_write(4'h4, 32'h0, 4'h1, e);
    bus_read(4'h4, 1'b1, rd);
    check("ovf_w0_keeps", rd, 32'h0000_080A);
    bus_write(4'h4, 32'h8, 4'h1, e);
    bus_read(4'h4, 1'b1, rd);
    check("ovf_w1c", rd, 32'h0000_0802);
    bus_write(4'hC, 32'h1, 4'h1, ee);
    for (int i = 0; i < 8; i++) ev_avail.push_back(ee);
    compute_pops(3);
    check_frames("burst8", 3, ee, 20);
    bus_read(4'h4, 1'b1, rd);
    check("burst8_drained", rd, 32'h0000_0004);

    // Push into a full FIFO on the edge the FSM pops
    bus_write(4'hC, 32'h0, 4'h1, e);
    ev_avail.delete();
    ev_byte.delete();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      bus_write(4'h0, {24'h0, b}, 4'h1, e);
      ev_byte.push_back(int'(b));
    end
    bus_write(4'hC, 32'h1, 4'h1, ee);
    b = 8'($urandom);
    bus_write(4'h0, {24'h0, b}, 4'h1, e9);
    ev_byte.push_back(int'(b));
    bus_read(4'h4, 1'b1, rd);
    check("full_pushpop_status", rd, 32'h0000_0803);
    for (int i = 0; i < 8; i++) ev_avail.push_back(ee);
    ev_avail.push_back(e9);
    compute_pops(3);
    check_frames("full_pushpop", 3, ee, 20);

    // Asynchronous reset in the middle of a data bit
    bus_write(4'h8, 32'h7, 4'h3, e);
    bus_write(4'h0, 32'h00, 4'h1, e);
    wait_log(e + 29);
    check("prereset_txd_low", {31'b0, txd}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("async_reset_txd", {31'b0, txd}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(4'h4, 1'b1, rd);
    check("postreset_status", rd, 32'h0000_0004);
    bus_read(4'h8, 1'b1, rd);
    check("postreset_bauddiv", rd, 32'h0000_01B1);
    bus_read(4'hC, 1'b1, rd);
    check("postreset_ctrl", rd, 32'h0000_0001);
    lo = txd_log.size();
    wait_log(lo + 60);
    e = -1;
    for (int i = lo; i < lo + 60; i++) if (e < 0 && txd_log[i] != 1'b1) e = i - lo;
    n_tests++;
    if (e >= 0) begin
      n_fail++;
      $display("FAIL postreset_idle: txd=0 at cycle %0d after reset release, expected 1", e);
    end

    // Random bytes, divisors and push spacing against the frame timing model
    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(1, 4);
      bus_write(4'h8, div, 4'h3, e);
      nb = $urandom_range(1, 6);
      ev_avail.delete();
      ev_byte.delete();
      for (int i = 0; i < nb; i++) begin
        gap = $urandom_range(0, 25);
        repeat (gap) @(posedge clk);
        b = 8'($urandom);
        bus_write(4'h0, {24'h0, b}, 4'h1, e);
        ev_avail.push_back(e);
        ev_byte.push_back(int'(b));
      end
      compute_pops(div);
      check_frames($sformatf("rand%0d", it), div, ev_avail[0], 12);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
